mux_stream_n: RTL
=================

Name: mux_stream_n

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with registered output and valid/ready handshake on every channel.
- Successor to the fixed 5:1 datapath muxes; it is shared by requesters that contend for one consumer (e.g. memory port, register-write bus).
- Two modes: control-unit selection (selector port) or round-robin arbitration.
- Output is a one-entry pipeline register with optional skid stage.

Parameters:
- WIDTH, 32, data width per channel
- N_IN, 5, number of input channels (2..16)
- SEL_W, $clog2(N_IN), selector/channel-index width (derived; never overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = selected mode, 1 = round-robin mode
- selector  in  SEL_W  channel index used in selected mode
- in_valid  in  N_IN  per-channel valid
- in_data  in  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  out  N_IN  per-channel ready; one-hot or zero
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered data
- out_chan  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts data
- sel_err  out  1  registered one-cycle pulse: selector >= N_IN while in selected mode

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, out_data=0, out_chan=0, sel_err=0, rr_ptr=0, FSM=EMPTY. in_ready=0 while reset is asserted.
- Reset release is synchronous to clk. Reset mid-transfer discards the held word.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Output slot is free when state==EMPTY, or state==FULL and out_ready=1.
- Grant g, computed combinationally each cycle:
  - Selected mode: g = selector when selector < N_IN and in_valid[selector]=1; otherwise no grant.
  - Round-robin mode: g = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_IN. No grant if all in_valid=0.
- in_ready[g] = slot free. All other in_ready bits are 0.
- Transfer occurs when in_valid[g] and in_ready[g] are both 1. On the next edge: out_data <= in_data[g], out_chan <= g, FSM goes to FULL.
- Latency is 1 cycle from input transfer to out_valid.
- rr_ptr <= (g+1) mod N_IN on each round-robin transfer; wrap N_IN-1 -> 0. rr_ptr is unchanged in selected mode.
- FULL, out_ready=1, no new transfer -> EMPTY.
- FULL, out_ready=1, new transfer in the same cycle -> stays FULL with new data. Full throughput: 1 word/cycle.
- FULL, out_ready=0 -> out_data and out_chan held stable; all in_ready=0.
- A mode or selector change takes effect only on the next grant. The word already held in the output register is unaffected.
- sel_err is 1 for exactly one cycle after any cycle with mode=0 and selector >= N_IN, regardless of in_valid.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro MUX_STREAM_N_SKID_EN.
- Defined:
  - Adds a second one-entry skid register.
  - Slot-free becomes "skid register empty", so in_ready no longer depends combinationally on out_ready.
  - When the output register is stalled, a transfer lands in the skid register. The skid word moves to the output register on the first cycle out_ready=1.
  - Throughput stays 1 word/cycle and ordering is preserved.
- Not defined: single output register as described above; in_ready depends on out_ready.

Decomposition:
- Package mux_stream_pkg holds:
  - MODE_SEL=1'b0, MODE_RR=1'b1 constants
  - state typedef {EMPTY, FULL}
  - default WIDTH and N_IN constants
- Sub-module rr_pick (N_IN, SEL_W): combinational rotate-priority find-first with inputs req and ptr, outputs grant_idx and grant_vld. It is reused by future arbiters.

Test Plan:
- Selected, N_IN=5: selector=3, in_valid=5'b01000, in_data[3]=32'hCAFE0003, out_ready=1 -> in_ready=5'b01000; next cycle out_valid=1, out_data=32'hCAFE0003, out_chan=3.
- Selected, selector=6 for one cycle, all in_valid=1 -> in_ready=0; sel_err=1 for exactly one cycle after; no output transfer.
- Round-robin: all in_valid=1, out_ready=1 for 7 cycles -> out_chan sequence 0,1,2,3,4,0,1.
- Backpressure: FULL with 32'h11, out_ready=0 for 4 cycles -> out_data stays 32'h11, in_ready=0. out_ready=1 -> pending channel transfers in the same cycle, back-to-back.
- Reset asserted while FULL mid-stream -> out_valid=0, rr_ptr=0 immediately without a clock edge. After release, first round-robin grant goes to channel 0.
- With MUX_STREAM_N_SKID_EN: out_ready=0, two words offered -> first in output register, second in skid register, then in_ready=0. Release -> both delivered in order on consecutive cycles.

Source files
------------

// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: mode constants, output-register state encoding and default sizes for mux_stream_n.
package mux_stream_pkg;
    localparam logic MODE_SEL  = 1'b0;
    localparam logic MODE_RR   = 1'b1;
    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_N_IN  = 5;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority find-first; picks the first set req bit starting at ptr and wrapping modulo N_IN.
module rr_pick #(
    parameter int N_IN  = 5,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);
    // Walk from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (req[SEL_W'((int'(ptr) + i) % N_IN)]) begin
                grant_idx = SEL_W'((int'(ptr) + i) % N_IN);
                grant_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_stream_n.sv
// mux_stream_n: N-input valid/ready stream mux with registered output, selected or round-robin grant.
// Define MUX_STREAM_N_SKID_EN to add a skid register that decouples in_ready from out_ready.
module mux_stream_n
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selector,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    input  logic                    out_ready,
    output logic                    sel_err
);
    localparam int NP = 2 ** SEL_W;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, rr_idx, g, rr_nxt, load_chan;
    logic               rr_vld, gvld, sel_ok, slot_free, xfer, load;
    logic [NP-1:0]      vpad;
    logic [WIDTH-1:0]   din [N_IN];
    logic [WIDTH-1:0]   load_data;

    for (genvar k = 0; k < N_IN; k++) begin : g_unpack
        assign din[k] = in_data[k*WIDTH +: WIDTH];
    end

    rr_pick #(.N_IN(N_IN), .SEL_W(SEL_W)) u_rr (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Padding lets an out-of-range selector index valid safely; sel_ok masks it anyway.
    assign vpad     = NP'(in_valid);
    assign sel_ok   = int'(selector) < N_IN;
    assign g        = mode == MODE_RR ? rr_idx : selector;
    assign gvld     = mode == MODE_RR ? rr_vld : sel_ok && vpad[selector];
    assign rr_nxt   = int'(g) == N_IN - 1 ? '0 : g + 1'b1;
    assign in_ready = (reset && gvld && slot_free) ? (N_IN'(1) << g) : '0;
    assign xfer     = |in_ready;

`ifdef MUX_STREAM_N_SKID_EN
    logic               skid_full, out_load, skid_mv;
    logic [WIDTH-1:0]   skid_data;
    logic [SEL_W-1:0]   skid_chan;

    assign slot_free = !skid_full;
    assign out_load  = xfer && (state == EMPTY || out_ready);
    assign skid_mv   = skid_full && out_ready;
    assign load      = out_load || skid_mv;
    assign load_data = skid_mv ? skid_data : din[g];
    assign load_chan = skid_mv ? skid_chan : g;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_chan <= '0;
        end else if (xfer && !out_load) begin
            skid_full <= 1'b1;
            skid_data <= din[g];
            skid_chan <= g;
        end else if (skid_mv) begin
            skid_full <= 1'b0;
        end
    end
`else
    assign slot_free = state == EMPTY || out_ready;
    assign load      = xfer;
    assign load_data = din[g];
    assign load_chan = g;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = load ? FULL : out_ready ? EMPTY : state;
    end

    assign out_valid = state == FULL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_chan <= '0;
            sel_err  <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            sel_err <= mode == MODE_SEL && !sel_ok;
            if (load) begin
                out_data <= load_data;
                out_chan <= load_chan;
            end
            if (xfer && mode == MODE_RR) rr_ptr <= rr_nxt;
        end
    end
endmodule
